// File: rtl/radar_pkg.sv
// Shared definitions for the radar pulse/echo link: FSM encodings and physical constants.
package radar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DELAY  = 2'b01,
    ECHO   = 2'b10,
    UPDATE = 2'b11
  } emu_state_t;

  localparam int unsigned LIGHT_SPEED = 300000000;

endpackage

// File: rtl/pulse_edge_detect.sv
// Synchronous rising-edge detector: rise is high for the cycle in which sig is high
// and was low at the previous clock edge.
module pulse_edge_detect (
  input  logic CLK,
  input  logic RST,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge CLK) begin
    if (RST) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/radar_target_emulator.sv
// Target model: answers each accepted trigger rise with an echo after the round-trip
// delay for the current distance, then closes the distance by closing_speed.
module radar_target_emulator
  import radar_pkg::*;
#(
  parameter int ECHO_WIDTH          = 1,
  parameter int RANGE_LIMIT         = 38250,
  parameter int METRES_PER_CYCLE_RT = 150
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        radar_pulse_trigger,
  input  logic        target_enable,
  input  logic        load,
  input  logic [31:0] initial_distance,
  input  logic [31:0] closing_speed,
  output logic        radar_echo,
  output logic [31:0] current_distance,
  output logic [1:0]  emulator_state,
  output logic [7:0]  missed_pulse_count
);

  emu_state_t  state, state_next;
  logic [7:0]  delay_cnt, delay_next;
  logic [7:0]  width_cnt, width_next;
  logic [7:0]  miss_next;
  logic        echo_next;
  logic [31:0] dist_next;
  logic [7:0]  delay_init;
  logic        trig_rise;
  logic        in_range;

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] a);
    return (a == 8'hFF) ? a : (a + 8'd1);
  endfunction

  pulse_edge_detect u_trig_edge (
    .CLK  (CLK),
    .RST  (RST),
    .sig  (radar_pulse_trigger),
    .rise (trig_rise)
  );

  // Quotient fits in 8 bits because distances above RANGE_LIMIT are never accepted.
  assign delay_init = 8'(current_distance / 32'(METRES_PER_CYCLE_RT));
  assign in_range   = target_enable && (current_distance != '0) &&
                      (current_distance <= 32'(RANGE_LIMIT));

  always_comb begin
    state_next = state;
    delay_next = delay_cnt;
    width_next = width_cnt;
    echo_next  = radar_echo;
    dist_next  = current_distance;
    miss_next  = missed_pulse_count;
    case (state)
      IDLE: begin
        // A load on the same cycle as a rise swallows the rise.
        if (load) begin
          dist_next = initial_distance;
        end else if (trig_rise && in_range) begin
          delay_next = delay_init;
          state_next = DELAY;
        end
      end
      DELAY: begin
        if (delay_cnt == '0) begin
          echo_next  = 1'b1;
          width_next = 8'(ECHO_WIDTH - 1);
          state_next = ECHO;
        end else begin
          delay_next = delay_cnt - 8'd1;
        end
      end
      ECHO: begin
        if (width_cnt == '0) begin
          echo_next  = 1'b0;
          state_next = UPDATE;
        end else begin
          width_next = width_cnt - 8'd1;
        end
      end
      UPDATE: begin
        dist_next  = sat_sub(current_distance, closing_speed);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (trig_rise && (state != IDLE)) miss_next = sat_inc(missed_pulse_count);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state              <= IDLE;
      delay_cnt          <= '0;
      width_cnt          <= '0;
      radar_echo         <= 1'b0;
      current_distance   <= '0;
      missed_pulse_count <= '0;
    end else begin
      state              <= state_next;
      delay_cnt          <= delay_next;
      width_cnt          <= width_next;
      radar_echo         <= echo_next;
      current_distance   <= dist_next;
      missed_pulse_count <= miss_next;
    end
  end

  assign emulator_state = state;

endmodule

// File: tb/tb_radar_target_emulator.sv
// Scoreboard bench for radar_target_emulator: two instances (echo width 1 and 3) share stimulus.
module tb_radar_target_emulator;

  localparam int EW_A = 1;
  localparam int EW_B = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        trig;
  logic        en;
  logic        load;
  logic [31:0] init_dist;
  logic [31:0] speed;

  logic        echo_a, echo_b;
  logic [31:0] dist_a, dist_b;
  logic [1:0]  state_a, state_b;
  logic [7:0]  miss_a, miss_b;

  radar_target_emulator #(.ECHO_WIDTH(EW_A), .RANGE_LIMIT(38250), .METRES_PER_CYCLE_RT(150)) dut_a (
    .CLK(CLK), .RST(RST), .radar_pulse_trigger(trig), .target_enable(en), .load(load),
    .initial_distance(init_dist), .closing_speed(speed), .radar_echo(echo_a),
    .current_distance(dist_a), .emulator_state(state_a), .missed_pulse_count(miss_a));

  radar_target_emulator #(.ECHO_WIDTH(EW_B), .RANGE_LIMIT(38250), .METRES_PER_CYCLE_RT(150)) dut_b (
    .CLK(CLK), .RST(RST), .radar_pulse_trigger(trig), .target_enable(en), .load(load),
    .initial_distance(init_dist), .closing_speed(speed), .radar_echo(echo_b),
    .current_distance(dist_b), .emulator_state(state_b), .missed_pulse_count(miss_b));

  always #5 CLK = ~CLK;

  // Edge counter: after posedge n, cyc == n.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: return 32'(echo_a);
      1: return dist_a;
      2: return 32'(state_a);
      3: return 32'(miss_a);
      4: return 32'(echo_b);
      5: return dist_b;
      6: return 32'(state_b);
      default: return 32'(miss_b);
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    int   i;
    e.cyc = c;
    e.sel = sel;
    e.val = v;
    e.tag = $sformatf("%s.%s", (sel < 4) ? "a" : "b", tag);
    if (sb.size() == 0 || sb[sb.size()-1].cyc <= c) begin
      sb.push_back(e);
    end else begin
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, e);
    end
  endtask

  task automatic check_due();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $error("FAIL %s: entry for cycle %0d not checked until cycle %0d", e.tag, e.cyc, cyc);
      end else begin
        assert (o === e.val) else begin
          errors++;
          $error("FAIL %s @cycle %0d: observed %0d expected %0d", e.tag, cyc, o, e.val);
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      check_due();
    end
  endtask

  // Idle snapshot for both instances at edge c.
  task automatic idle_expect(input int c, input logic [31:0] d, input logic [7:0] m);
    for (int b = 0; b < 8; b += 4) begin
      expect_at(c, b + 0, 32'd0, "echo");
      expect_at(c, b + 1, d, "dist");
      expect_at(c, b + 2, 32'd0, "state");
      expect_at(c, b + 3, 32'(m), "miss");
    end
  endtask

  // Nominal transaction for a rise sampled at edge k, checked up to edge 'last'.
  task automatic push_one(input int k, input int ew, input int base, input int d, input int s, input int last);
    int          dd;
    int          fin;
    logic [31:0] st;
    dd  = d / 150;
    fin = k + 2 + dd + ew;
    for (int e = k; e <= fin && e <= last; e++) begin
      if (e == fin)           st = 32'd0;
      else if (e == fin - 1)  st = 32'd3;
      else if (e >= k + 1 + dd) st = 32'd2;
      else                    st = 32'd1;
      expect_at(e, base + 2, st, "state");
      expect_at(e, base + 0, (e >= k + 1 + dd && e <= k + dd + ew) ? 32'd1 : 32'd0, "echo");
      expect_at(e, base + 1, (e == fin) ? ((d > s) ? 32'(d - s) : 32'd0) : 32'(d), "dist");
    end
  endtask

  task automatic txn(input int k, input int d, input int s, input int last);
    push_one(k, EW_A, 0, d, s, last);
    push_one(k, EW_B, 4, d, s, last);
  endtask

  task automatic miss_expect(input int c, input logic [7:0] m);
    expect_at(c, 3, 32'(m), "miss");
    expect_at(c, 7, 32'(m), "miss");
  endtask

  task automatic load_dist(input logic [31:0] d, input logic [7:0] m);
    load      = 1'b1;
    init_dist = d;
    idle_expect(cyc + 1, d, m);
    tick(1);
    load = 1'b0;
  endtask

  task automatic no_echo(input logic [31:0] d, input logic en_val);
    load_dist(d, 8'd0);
    en   = en_val;
    trig = 1'b1;
    for (int j = 1; j <= 4; j++) idle_expect(cyc + j, d, 8'd0);
    tick(4);
    trig = 1'b0;
    en   = 1'b1;
    tick(1);
  endtask

  localparam int NO_LIMIT = 32'h7fff_ffff;

  initial begin
    int k;
    int guard;
    RST = 1'b1; trig = 1'b0; en = 1'b1; load = 1'b0; init_dist = '0; speed = '0;

    // Reset values
    tick(1);
    idle_expect(cyc + 1, 32'd0, 8'd0);
    tick(1);
    RST = 1'b0;
    tick(1);

    // 1500 m, speed 100, trigger held high for the whole exchange
    speed = 32'd100;
    load_dist(32'd1500, 8'd0);
    trig = 1'b1;
    k = cyc + 1;
    txn(k, 1500, 100, NO_LIMIT);
    miss_expect(k + 15, 8'd0);
    tick(16);
    trig = 1'b0;
    tick(1);

    // D = 0 and saturating distance update
    speed = 32'd200;
    load_dist(32'd100, 8'd0);
    trig = 1'b1;
    k = cyc + 1;
    txn(k, 100, 200, NO_LIMIT);
    tick(6);
    trig = 1'b0;
    tick(1);

    // Rejected triggers
    no_echo(32'd40000, 1'b1);
    no_echo(32'd38251, 1'b1);
    no_echo(32'd1500, 1'b0);
    no_echo(32'd0, 1'b1);

    // Load and rise on the same idle cycle: load wins, no echo, no miss
    speed     = 32'd100;
    load      = 1'b1;
    init_dist = 32'd3000;
    trig      = 1'b1;
    for (int j = 1; j <= 4; j++) idle_expect(cyc + j, 32'd3000, 8'd0);
    tick(1);
    load = 1'b0;
    tick(3);
    trig = 1'b0;
    tick(1);

    // Load during DELAY is ignored
    trig = 1'b1;
    k = cyc + 1;
    txn(k, 3000, 100, NO_LIMIT);
    tick(3);
    load      = 1'b1;
    init_dist = 32'd500;
    tick(1);
    load = 1'b0;
    trig = 1'b0;
    tick(k + 25 - cyc);

    // Reset while the echo is high, then a nominal exchange
    trig = 1'b1;
    k = cyc + 1;
    txn(k, 2900, 100, k + 20);
    tick(k + 20 - cyc);
    RST  = 1'b1;
    trig = 1'b0;
    idle_expect(k + 21, 32'd0, 8'd0);
    tick(1);
    RST = 1'b0;
    load_dist(32'd1500, 8'd0);
    trig = 1'b1;
    k = cyc + 1;
    txn(k, 1500, 100, NO_LIMIT);
    tick(16);
    trig = 1'b0;
    tick(1);

    // Three rises during DELAY: counted, echo timing unchanged
    load_dist(32'd1500, 8'd0);
    trig = 1'b1;
    k = cyc + 1;
    txn(k, 1500, 100, NO_LIMIT);
    tick(1);
    trig = 1'b0;
    repeat (3) begin
      tick(1);
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
    end
    miss_expect(k + 7, 8'd3);
    miss_expect(k + 15, 8'd3);
    tick(k + 15 - cyc);
    tick(1);

    // Maximum range (D = 255) with 120 busy rises per exchange: count saturates
    speed = 32'd0;
    load_dist(32'd38250, 8'd3);
    for (int b = 0; b < 3; b++) begin
      trig = 1'b1;
      k = cyc + 1;
      txn(k, 38250, 0, NO_LIMIT);
      tick(1);
      trig = 1'b0;
      repeat (120) begin
        tick(1);
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
      end
      miss_expect(k + 241, (3 + 120 * (b + 1) > 255) ? 8'd255 : 8'(3 + 120 * (b + 1)));
      tick(k + 260 - cyc);
      tick(1);
    end
    idle_expect(cyc + 1, 32'd38250, 8'd255);
    tick(1);

    // Drain anything still pending, bounded
    guard = 0;
    while (sb.size() > 0 && guard < 1000) begin
      tick(1);
      guard++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d pending entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
